// File: rtl/ave_pkg.sv
// Shared types, segment constants and helpers for the windowed
// averaging display.
package ave_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SHIFT,
        DONE
    } conv_state_e;

    // Segment order is {g,f,e,d,c,b,a}; a low bit lights the segment.
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam logic [6:0] SEG_DIGIT [0:9] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
        7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
    };

    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        if (nib < 4'd10) begin
            return SEG_DIGIT[nib];
        end
        return SEG_BLANK;
    endfunction

    function automatic int bcd_digits_needed(input int width);
        longint unsigned m;
        int n;
        m = (longint'(1) << width) - 1;
        n = 1;
        for (int i = 0; i < 20; i++) begin
            if (m >= 10) begin
                m = m / 10;
                n = n + 1;
            end
        end
        return n;
    endfunction

endpackage

// File: rtl/ave_window_display_bcd_seq_conv.sv
// Iterative double-dabble: one binary bit per cycle into a BCD
// accumulator, with a one-cycle DONE handshake.
module bcd_seq_conv
    import ave_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic [WIDTH-1:0]      bin_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [4*DIGITS-1:0]   bcd_o
);

    localparam int CW = $clog2(WIDTH + 1);

    conv_state_e           state_q, state_d;
    logic [WIDTH-1:0]      sh_q, sh_d;
    logic [4*DIGITS-1:0]   bcd_q, bcd_d;
    logic [4*DIGITS-1:0]   adj;
    logic [CW-1:0]         cnt_q, cnt_d;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            sh_q    <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sh_q    <= sh_d;
            bcd_q   <= bcd_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        adj = bcd_q;
        for (int k = 0; k < DIGITS; k++) begin
            if (bcd_q[4*k +: 4] >= 4'd5) begin
                adj[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        sh_d    = sh_q;
        bcd_d   = bcd_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                sh_d    = bin_i;
                bcd_d   = '0;
                cnt_d   = CW'(WIDTH);
                state_d = SHIFT;
            end
            SHIFT: begin
                {bcd_d, sh_d} = {adj, sh_q} << 1;
                cnt_d = cnt_q - 1'b1;
                if (cnt_d == '0) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                // Queued work restarts directly without an IDLE bubble.
                state_d = start_i ? LOAD : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy_o = (state_q != IDLE);
    assign done_o = (state_q == DONE);
    assign bcd_o  = bcd_q;

endmodule

// File: rtl/ave_window_display.sv
// Sliding-window average of strobed samples, shown in decimal on
// active-low seven-segment digits.
module ave_window_display
    import ave_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int LOG2_N   = 3,
    parameter int DIGITS   = 3,
    parameter int BLANK_LZ = 1
) (
    input  logic                  CLOCK,
    input  logic                  RESET,
    input  logic [WIDTH-1:0]      in0,
    input  logic                  enable,
    output logic [7*DIGITS-1:0]   seven_display,
    output logic [WIDTH-1:0]      avg_out,
    output logic                  busy,
    output logic                  valid,
    output logic                  window_full
);

    localparam int N  = 1 << LOG2_N;
    localparam int SW = WIDTH + LOG2_N;
    localparam logic [LOG2_N:0] FULL = (LOG2_N + 1)'(N);

    if (DIGITS < bcd_digits_needed(WIDTH)) begin : g_digits_check
        $error("DIGITS cannot represent 2**WIDTH-1");
    end

    function automatic logic [7*DIGITS-1:0] render(
        input logic [4*DIGITS-1:0] bcd
    );
        logic [7*DIGITS-1:0] seg;
        logic lead;
        seg  = '0;
        lead = 1'b1;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            if (BLANK_LZ != 0 && lead && k != 0 && bcd[4*k +: 4] == 4'd0) begin
                seg[7*k +: 7] = SEG_BLANK;
            end else begin
                lead = 1'b0;
                seg[7*k +: 7] = seg_decode(bcd[4*k +: 4]);
            end
        end
        return seg;
    endfunction

    logic                  s1_q, s2_q, s3_q;
    logic                  accept;
    logic [WIDTH-1:0]      win_q [N];
    logic [SW-1:0]         sum_q, sum_d;
    logic [LOG2_N-1:0]     wr_ptr_q;
    logic [LOG2_N:0]       fill_q;
    logic                  pending_q, pending_d;
    logic                  conv_start, conv_busy, conv_done;
    logic [4*DIGITS-1:0]   conv_bcd;
    logic [7*DIGITS-1:0]   seg_q;
    logic                  valid_q;

    assign accept = s2_q & ~s3_q;
    // Oldest sample leaves the sum in the same cycle its slot is reused.
    assign sum_d  = sum_q + SW'(in0) - SW'(win_q[wr_ptr_q]);

    assign conv_start = accept | pending_q;

    always_comb begin
        pending_d = pending_q;
        if (conv_done && conv_start) begin
            pending_d = 1'b0;
        end else if (accept && conv_busy) begin
            pending_d = 1'b1;
        end
    end

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            s1_q      <= 1'b0;
            s2_q      <= 1'b0;
            s3_q      <= 1'b0;
            sum_q     <= '0;
            wr_ptr_q  <= '0;
            fill_q    <= '0;
            pending_q <= 1'b0;
            seg_q     <= render('0);
            valid_q   <= 1'b0;
            for (int i = 0; i < N; i++) begin
                win_q[i] <= '0;
            end
        end else begin
            s1_q      <= enable;
            s2_q      <= s1_q;
            s3_q      <= s2_q;
            pending_q <= pending_d;
            valid_q   <= conv_done;
            if (accept) begin
                win_q[wr_ptr_q] <= in0;
                sum_q           <= sum_d;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
                if (fill_q != FULL) begin
                    fill_q <= fill_q + 1'b1;
                end
            end
            if (conv_done) begin
                seg_q <= render(conv_bcd);
            end
        end
    end

    bcd_seq_conv #(
        .WIDTH  (WIDTH),
        .DIGITS (DIGITS)
    ) u_conv (
        .clk_i   (CLOCK),
        .rst_i   (RESET),
        .start_i (conv_start),
        .bin_i   (avg_out),
        .busy_o  (conv_busy),
        .done_o  (conv_done),
        .bcd_o   (conv_bcd)
    );

    assign avg_out       = sum_q[SW-1:LOG2_N];
    assign busy          = conv_busy;
    assign valid         = valid_q;
    assign window_full   = (fill_q == FULL);
    assign seven_display = seg_q;

endmodule

// File: tb/tb_ave_window_display.sv
// Directed bench for the windowed averaging display at
// WIDTH=8, LOG2_N=3, DIGITS=3, BLANK_LZ=1.
module tb_ave_window_display;

    localparam logic [6:0] SB = 7'b1111111;
    localparam logic [6:0] S0 = 7'b1000000;
    localparam logic [6:0] S1 = 7'b1111001;
    localparam logic [6:0] S2 = 7'b0100100;
    localparam logic [6:0] S3 = 7'b0110000;
    localparam logic [6:0] S7 = 7'b1111000;

    logic        CLOCK = 1'b0;
    logic        RESET = 1'b1;
    logic [7:0]  in0 = '0;
    logic        enable = 1'b0;
    logic [20:0] seven_display;
    logic [7:0]  avg_out;
    logic        busy;
    logic        valid;
    logic        window_full;

    int n_checks = 0;
    int n_fail   = 0;
    int vcnt     = 0;
    int bcnt     = 0;
    int b2b      = 0;
    logic prev_v = 1'b0;
    int v0;
    int b0;

    ave_window_display #(
        .WIDTH    (8),
        .LOG2_N   (3),
        .DIGITS   (3),
        .BLANK_LZ (1)
    ) dut (
        .CLOCK         (CLOCK),
        .RESET         (RESET),
        .in0           (in0),
        .enable        (enable),
        .seven_display (seven_display),
        .avg_out       (avg_out),
        .busy          (busy),
        .valid         (valid),
        .window_full   (window_full)
    );

    always #5 CLOCK = ~CLOCK;

    always @(negedge CLOCK) begin
        if (valid) vcnt = vcnt + 1;
        if (valid && prev_v) b2b = b2b + 1;
        if (busy) bcnt = bcnt + 1;
        prev_v = valid;
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (got !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called at a negedge; returns at a negedge.
    task automatic pulse(input logic [7:0] v, input int hi, input int lo);
        in0    = v;
        enable = 1'b1;
        repeat (hi) @(negedge CLOCK);
        enable = 1'b0;
        repeat (lo) @(negedge CLOCK);
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        repeat (3) @(negedge CLOCK);
        while (busy && n < 200) begin
            @(negedge CLOCK);
            n++;
        end
        check(tag, {31'd0, busy}, 32'd0);
        repeat (2) @(negedge CLOCK);
    endtask

    task automatic do_reset();
        RESET  = 1'b1;
        enable = 1'b0;
        repeat (2) @(negedge CLOCK);
        RESET = 1'b0;
        repeat (2) @(negedge CLOCK);
    endtask

    initial begin
        int n;
        // 1: reset state
        repeat (3) @(negedge CLOCK);
        RESET = 1'b0;
        repeat (3) @(negedge CLOCK);
        check("rst_seg", seven_display, {SB, SB, S0});
        check("rst_avg", avg_out, 0);
        check("rst_busy", busy, 0);
        check("rst_wf", window_full, 0);
        check("rst_valid", valid, 0);

        // 2: single sample 255
        v0 = vcnt;
        b0 = bcnt;
        pulse(8'd255, 2, 3);
        wait_idle("idle_255");
        check("avg_255", avg_out, 31);
        check("busy_cycles", bcnt - b0, 10);
        check("valid_255", vcnt - v0, 1);
        check("seg_31", seven_display, {SB, S3, S1});
        check("wf_1", window_full, 0);

        // 3: fill window with 200
        do_reset();
        for (int i = 0; i < 7; i++) pulse(8'd200, 2, 3);
        repeat (3) @(negedge CLOCK);
        check("wf_7", window_full, 0);
        check("avg_7", avg_out, 175);
        pulse(8'd200, 2, 3);
        wait_idle("idle_200");
        check("wf_8", window_full, 1);
        check("avg_200", avg_out, 200);
        check("seg_200", seven_display, {S2, S0, S0});

        // 4: wrap overwrites the oldest sample
        do_reset();
        for (int i = 0; i < 8; i++) pulse(8'd80, 2, 3);
        wait_idle("idle_80");
        check("avg_80", avg_out, 80);
        pulse(8'd0, 2, 3);
        wait_idle("idle_wrap");
        check("sum_wrap", dut.sum_q, 560);
        check("avg_wrap", avg_out, 70);
        check("seg_70", seven_display, {SB, S7, S0});
        check("wf_wrap", window_full, 1);

        // 5: held enable, then coalesced pulses
        do_reset();
        v0 = vcnt;
        pulse(8'd10, 20, 5);
        wait_idle("idle_hold");
        check("sum_hold", dut.sum_q, 10);
        check("valid_hold", vcnt - v0, 1);
        v0 = vcnt;
        pulse(8'd30, 1, 2);
        pulse(8'd60, 1, 2);
        pulse(8'd90, 1, 2);
        wait_idle("idle_burst");
        check("sum_burst", dut.sum_q, 190);
        check("avg_burst", avg_out, 23);
        check("valid_burst", vcnt - v0, 2);
        check("seg_23", seven_display, {SB, S2, S3});
        check("no_b2b", b2b, 0);

        // 6: reset during conversion
        do_reset();
        v0 = vcnt;
        in0    = 8'd100;
        enable = 1'b1;
        n = 0;
        while (!busy && n < 20) begin
            @(negedge CLOCK);
            n++;
        end
        check("busy_rise", busy, 1);
        enable = 1'b0;
        repeat (4) @(negedge CLOCK);
        RESET = 1'b1;
        #1;
        check("mid_busy", busy, 0);
        check("mid_sum", dut.sum_q, 0);
        check("mid_seg", seven_display, {SB, SB, S0});
        check("mid_avg", avg_out, 0);
        repeat (2) @(negedge CLOCK);
        RESET = 1'b0;
        repeat (15) @(negedge CLOCK);
        check("mid_valid", vcnt - v0, 0);
        check("post_busy", busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
